// File: rtl/conv_addr_gen.sv
// conv_addr_gen: convolution-window address generator.
// For each job it walks output pixel -> input channel -> kernel tap and
// streams one flat input-map address per valid/ready beat. Stride is set
// per job; zero padding is fixed at elaboration. Beats that fall in the
// padding border are flagged so the consumer can substitute zero.
module conv_addr_gen #(
   parameter  int K   = 3,
   parameter  int N   = 2,
   parameter  int C   = 1,
   parameter  int P   = 0,
   localparam int W   = N * K,
   localparam int AW  = (C * W * W > 1) ? $clog2(C * W * W) : 1,
   localparam int SW  = (K > 1) ? $clog2(K) : 1,
   localparam int PXW = (N * N > 1) ? $clog2(N * N) : 1
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           start,
   input  logic [SW-1:0]  stride,
   output logic           busy,
   output logic           err,
   output logic           addr_valid,
   input  logic           addr_ready,
   output logic [AW-1:0]  addr,
   output logic           addr_pad,
   output logic [PXW-1:0] addr_pixel,
   output logic           addr_last,
   output logic           done
);

   localparam int KW  = (K > 1) ? $clog2(K) : 1;
   localparam int NW  = (N > 1) ? $clog2(N) : 1;
   localparam int CHW = (C > 1) ? $clog2(C) : 1;
   // Signed coordinate width: one bit for the sign, one spare above W.
   localparam int CW  = $clog2(W) + 2;
   localparam logic signed [CW-1:0] W_S = CW'(W);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t state, state_d;

   // Counters describing the beat currently presented on the output.
   logic [KW-1:0]  tcol, trow;
   logic [CHW-1:0] ch;
   logic [NW-1:0]  ocol, orow;
   logic [SW-1:0]  job_stride;

   logic [KW-1:0]  tcol_n, trow_n, sel_tcol, sel_trow;
   logic [CHW-1:0] ch_n, sel_ch;
   logic [NW-1:0]  ocol_n, orow_n, sel_ocol, sel_orow;
   logic [SW-1:0]  sel_stride;
   logic [PXW-1:0] pixel_n;

   logic last_tcol, last_trow, last_tap, last_ch, last_ocol, last_orow, last_beat;
   logic stride_ok, handshake, accept, reject, advance, finish;

   logic signed [CW-1:0] row, col;
   logic                 beat_pad, beat_last;
   logic [AW-1:0]        beat_addr;

   assign handshake = addr_valid && addr_ready;
   assign stride_ok = (stride != '0) && (int'(stride) <= K);

   assign last_tcol = (tcol == KW'(K - 1));
   assign last_trow = (trow == KW'(K - 1));
   assign last_tap  = last_tcol && last_trow;
   assign last_ch   = (ch == CHW'(C - 1));
   assign last_ocol = (ocol == NW'(N - 1));
   assign last_orow = (orow == NW'(N - 1));
   assign last_beat = last_tap && last_ch && last_ocol && last_orow;

   // Nested-loop increment: tap column, tap row, channel, pixel column, pixel row.
   always_comb begin
      // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
      tcol_n  = last_tcol ? '0 : tcol + 1'b1;
      trow_n  = trow;
      ch_n    = ch;
      ocol_n  = ocol;
      orow_n  = orow;
      pixel_n = addr_pixel;
      if (last_tcol) trow_n = last_trow ? '0 : trow + 1'b1;
      if (last_tap)  ch_n   = last_ch ? '0 : ch + 1'b1;
      if (last_tap && last_ch) begin
         ocol_n  = last_ocol ? '0 : ocol + 1'b1;
         pixel_n = addr_pixel + 1'b1;
         if (last_ocol) orow_n = last_orow ? '0 : orow + 1'b1;
      end
   end

   // Counters of the beat about to be loaded: origin on start, successor otherwise.
   always_comb begin
      sel_tcol   = tcol_n;
      sel_trow   = trow_n;
      sel_ch     = ch_n;
      sel_ocol   = ocol_n;
      sel_orow   = orow_n;
      sel_stride = job_stride;
      if (state == IDLE) begin
         sel_tcol   = '0;
         sel_trow   = '0;
         sel_ch     = '0;
         sel_ocol   = '0;
         sel_orow   = '0;
         sel_stride = stride;
      end
   end

   // Window coordinates, border test and flat address of the selected beat.
   always_comb begin
      row       = CW'(sel_trow) + CW'(sel_stride) * CW'(sel_orow) - CW'(P);
      col       = CW'(sel_tcol) + CW'(sel_stride) * CW'(sel_ocol) - CW'(P);
      beat_pad  = row[CW-1] || (row >= W_S) || col[CW-1] || (col >= W_S);
      beat_addr = '0;
      if (!beat_pad)
         beat_addr = AW'(sel_ch) * AW'(W * W) + AW'($unsigned(row)) * AW'(W)
                   + AW'($unsigned(col));
      beat_last = (sel_ch == CHW'(C - 1)) && (sel_trow == KW'(K - 1))
               && (sel_tcol == KW'(K - 1));
   end

   // Next-state and control strobes.
   always_comb begin
      state_d = state;
      accept  = 1'b0;
      reject  = 1'b0;
      advance = 1'b0;
      finish  = 1'b0;
      case (state)
         IDLE: if (start) begin
            if (stride_ok) begin
               accept  = 1'b1;
               state_d = RUN;
            end else begin
               reject  = 1'b1;
            end
         end
         RUN: if (handshake) begin
            if (last_beat) begin
               finish  = 1'b1;
               state_d = DONE;
            end else begin
               advance = 1'b1;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk) begin
      // NOTE: clocked state uses non-blocking assignments so all registers update from pre-edge values.
      if (rst) state <= IDLE;
      else     state <= state_d;
   end

   // Registered outputs and loop counters; a beat only changes on start or handshake.
   always_ff @(posedge clk) begin
      if (rst) begin
         busy       <= 1'b0;
         err        <= 1'b0;
         done       <= 1'b0;
         addr_valid <= 1'b0;
         addr       <= '0;
         addr_pad   <= 1'b0;
         addr_pixel <= '0;
         addr_last  <= 1'b0;
         tcol       <= '0;
         trow       <= '0;
         ch         <= '0;
         ocol       <= '0;
         orow       <= '0;
         job_stride <= '0;
      end else begin
         busy <= (state_d != IDLE);
         err  <= reject;
         done <= finish;
         if (accept || advance) begin
            tcol       <= sel_tcol;
            trow       <= sel_trow;
            ch         <= sel_ch;
            ocol       <= sel_ocol;
            orow       <= sel_orow;
            addr       <= beat_addr;
            addr_pad   <= beat_pad;
            addr_last  <= beat_last;
            addr_valid <= 1'b1;
            addr_pixel <= accept ? '0 : pixel_n;
         end else if (finish) begin
            addr_valid <= 1'b0;
         end
         if (accept) job_stride <= stride;
      end
   end

endmodule
